// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, arbiter FSM states and bus words.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Strobes and payload presented to the RAM in a given cycle.
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_req_t;

  localparam ram_req_t RAM_REQ_IDLE = '{ren: 1'b0, wen: 1'b0, addr: '0, store: '0};

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while an instruction fetch is waiting.
module arb_starve_cnt #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat_c
);

  localparam int unsigned CW = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count sticks at MAX until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_c = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access; data wins by default.
// Define ARB_STARVE_EN to let a waiting fetch through after STARVE_MAX consecutive data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       ihit,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dhit,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate
);

  arb_state_t state_q, state_d;
  ram_req_t   ram_c;
  ramstate_t  rs_c;
  logic       d_req_c;
  logic       i_first_c;

  assign rs_c    = ramstate_t'(ramstate);
  assign d_req_c = dREN | dWEN;

  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

`ifdef ARB_STARVE_EN
  logic starve_sat_c;
  logic starve_inc_c;
  logic starve_clr_c;

  // Count data grants taken over a waiting fetch; any fetch grant or idle fetch side resets it.
  assign starve_inc_c = (state_q == IDLE) && (state_d == DGRANT) && iREN;
  assign starve_clr_c = (state_q == IDLE) && ((state_d == IGRANT) || !iREN);

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (starve_inc_c),
    .clr   (starve_clr_c),
    .sat_c (starve_sat_c)
  );

  assign i_first_c = iREN & starve_sat_c;
`else
  assign i_first_c = 1'b0;
`endif

  // Next state, RAM strobes and completion pulses all follow the live request inputs.
  always_comb begin
    state_d = state_q;
    ram_c   = RAM_REQ_IDLE;
    ihit    = 1'b0;
    dhit    = 1'b0;
    iload   = '0;
    dload   = '0;
    case (state_q)
      IDLE: begin
        if (d_req_c && !i_first_c) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        ram_c.ren  = 1'b1;
        ram_c.addr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (rs_c == ACCESS) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = IDLE;
        end
      end
      DGRANT: begin
        ram_c = '{ren: dREN, wen: dWEN, addr: daddr, store: dstore};
        if (!d_req_c) begin
          state_d = IDLE;
        end else if (rs_c == ACCESS) begin
          dhit    = 1'b1;
          dload   = ramload;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ramREN   = ram_c.ren;
  assign ramWEN   = ram_c.wen;
  assign ramaddr  = ram_c.addr;
  assign ramstore = ram_c.store;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a grant-owner model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned TB_STARVE_MAX = 2;
  localparam int unsigned N_RAND        = 600;

  typedef struct packed {
    logic  ihit;
    word_t iload;
    logic  dhit;
    word_t dload;
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } obs_t;

  logic       CLK;
  logic       nRST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, ramload;
  logic [1:0] ramstate;
  logic       ihit, dhit, ramREN, ramWEN;
  word_t      iload, dload, ramaddr, ramstore;

  int          n_checks;
  int          n_fails;
  int          m_owner;   // who owns the RAM: 0 nobody, 1 fetch, 2 data
  int unsigned m_cnt;     // data grants taken while a fetch waited

  mem_arbiter #(
    .STARVE_MAX (TB_STARVE_MAX)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .ihit     (ihit),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_checks=%0d", n_checks);
    $fatal(1, "bench did not finish");
  end

  function automatic obs_t sample();
    obs_t s;
    s.ihit  = ihit;
    s.iload = iload;
    s.dhit  = dhit;
    s.dload = dload;
    s.ren   = ramREN;
    s.wen   = ramWEN;
    s.addr  = ramaddr;
    s.store = ramstore;
    return s;
  endfunction

  function automatic obs_t mk(input logic ih, input word_t il, input logic dh, input word_t dl,
                              input logic re, input logic we, input word_t a, input word_t st);
    obs_t e;
    e.ihit  = ih;
    e.iload = il;
    e.dhit  = dh;
    e.dload = dl;
    e.ren   = re;
    e.wen   = we;
    e.addr  = a;
    e.store = st;
    return e;
  endfunction

  // Expected outputs this cycle given the current owner and the live inputs.
  function automatic obs_t model_out();
    obs_t e;
    e = '0;
    if (m_owner == 1) begin
      e.ren  = 1'b1;
      e.addr = iaddr;
      if (iREN && (ramstate == ACCESS)) begin
        e.ihit  = 1'b1;
        e.iload = ramload;
      end
    end else if (m_owner == 2) begin
      e.ren   = dREN;
      e.wen   = dWEN;
      e.addr  = daddr;
      e.store = dstore;
      if ((dREN || dWEN) && (ramstate == ACCESS)) begin
        e.dhit  = 1'b1;
        e.dload = ramload;
      end
    end
    return e;
  endfunction

  // Ownership after the coming clock edge, from the arbitration rules.
  task automatic model_step();
    logic d_req;
    logic done;
    d_req = dREN | dWEN;
    done  = (ramstate == ACCESS);
    if (!nRST) begin
      m_owner = 0;
      m_cnt   = 0;
      return;
    end
    if (m_owner == 0) begin
`ifdef ARB_STARVE_EN
      if (iREN && (m_cnt == TB_STARVE_MAX)) m_owner = 1;
      else if (d_req) m_owner = 2;
      else if (iREN) m_owner = 1;
      if (!iREN || (m_owner == 1)) m_cnt = 0;
      else if ((m_owner == 2) && (m_cnt < TB_STARVE_MAX)) m_cnt = m_cnt + 1;
`else
      if (d_req) m_owner = 2;
      else if (iREN) m_owner = 1;
`endif
    end else if (m_owner == 1) begin
      if (!iREN || done) m_owner = 0;
    end else begin
      if (!d_req || done) m_owner = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t zero;
    zero     = '0;
    nRST     = 1'b0;
    iREN     = 1'b1;
    dREN     = 1'b1;
    dWEN     = 1'b0;
    iaddr    = 32'h0000_1000;
    daddr    = 32'h0000_2000;
    dstore   = 32'h0000_3000;
    ramload  = 32'h5555_AAAA;
    ramstate = ACCESS;
    m_owner  = 0;
    m_cnt    = 0;
    #3;
    got = sample(); n_checks++;
    if (got !== zero) begin n_fails++; $display("FAIL reset_outputs got=%h want=%h", got, zero); end
    @(posedge CLK); #1;
    got = sample(); n_checks++;
    if (got !== zero) begin n_fails++; $display("FAIL reset_hold got=%h want=%h", got, zero); end
    set_idle();
    nRST = 1'b1;
    #1;
    got = sample(); n_checks++;
    if (got !== zero) begin n_fails++; $display("FAIL reset_release got=%h want=%h", got, zero); end
    tick();
    got = sample(); n_checks++;
    if (got !== zero) begin n_fails++; $display("FAIL idle_no_req got=%h want=%h", got, zero); end
  endtask

  task automatic test_ifetch();
    obs_t got, want;
    set_idle();
    iREN    = 1'b1;
    iaddr   = 32'h0000_0040;
    ramload = 32'hDEAD_BEEF;
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL ifetch_c1 got=%h want=%h", got, want); end
    tick();
    ramstate = ACCESS;
    #1;
    got = sample(); want = mk(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b1, 1'b0, 32'h40, '0); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL ifetch_c2 got=%h want=%h", got, want); end
    tick();
    set_idle();
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL ifetch_c3 got=%h want=%h", got, want); end
    tick();
  endtask

  task automatic test_priority();
    obs_t got, want;
    set_idle();
    iREN     = 1'b1;
    iaddr    = 32'h0000_0100;
    dWEN     = 1'b1;
    daddr    = 32'h0000_0080;
    dstore   = 32'h0000_1234;
    ramstate = ACCESS;
    ramload  = 32'hCAFE_0001;
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL prio_idle got=%h want=%h", got, want); end
    tick();
    got = sample(); want = mk(1'b0, '0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 32'h80, 32'h1234); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL prio_dgrant got=%h want=%h", got, want); end
    tick();
    dWEN = 1'b0;
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL prio_gap got=%h want=%h", got, want); end
    tick();
    got = sample(); want = mk(1'b1, 32'hCAFE_0001, 1'b0, '0, 1'b1, 1'b0, 32'h100, '0); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL prio_igrant got=%h want=%h", got, want); end
    tick();
    set_idle();
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL prio_done got=%h want=%h", got, want); end
    tick();
  endtask

  task automatic test_busy_hold();
    obs_t got, want;
    set_idle();
    dREN     = 1'b1;
    daddr    = 32'h0000_0200;
    ramstate = BUSY;
    ramload  = 32'h0BAD_F00D;
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL busy_c1 got=%h want=%h", got, want); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      got = sample(); want = mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h200, '0); n_checks++;
      if (got !== want) begin n_fails++; $display("FAIL busy_c%0d got=%h want=%h", k, got, want); end
    end
    tick();
    ramstate = ACCESS;
    ramload  = 32'h600D_F00D;
    #1;
    got = sample(); want = mk(1'b0, '0, 1'b1, 32'h600D_F00D, 1'b1, 1'b0, 32'h200, '0); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL busy_c5 got=%h want=%h", got, want); end
    tick();
    set_idle();
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL busy_done got=%h want=%h", got, want); end
    tick();
  endtask

  task automatic test_abort();
    obs_t got, want;
    set_idle();
    iREN     = 1'b1;
    iaddr    = 32'h0000_0300;
    ramstate = ERROR;
    tick();
    got = sample(); want = mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h300, '0); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL abort_hold_error got=%h want=%h", got, want); end
    iREN     = 1'b0;
    ramstate = ACCESS;
    #1;
    got = sample(); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL abort_i_drop got=%h want=%h", got, want); end
    tick();
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL abort_i_idle got=%h want=%h", got, want); end
    dREN     = 1'b1;
    daddr    = 32'h0000_0310;
    dstore   = 32'h0000_0077;
    ramstate = FREE;
    tick();
    dREN     = 1'b0;
    ramstate = ACCESS;
    #1;
    got = sample(); want = mk(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h310, 32'h77); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL abort_d_drop got=%h want=%h", got, want); end
    tick();
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL abort_d_idle got=%h want=%h", got, want); end
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    set_idle();
    dREN     = 1'b1;
    daddr    = 32'h0000_0400;
    ramstate = BUSY;
    ramload  = 32'h1357_9BDF;
    tick();
    got = sample(); want = mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h400, '0); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL rmid_dgrant got=%h want=%h", got, want); end
    #2;
    nRST     = 1'b0;
    ramstate = ACCESS;
    #1;
    got = sample(); want = '0; n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL rmid_async got=%h want=%h", got, want); end
    @(posedge CLK); #1;
    got = sample(); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL rmid_hold got=%h want=%h", got, want); end
    nRST    = 1'b1;
    m_owner = 0;
    m_cnt   = 0;
    #1;
    got = sample(); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL rmid_release_idle got=%h want=%h", got, want); end
    tick();
    got = sample(); want = mk(1'b0, '0, 1'b1, 32'h1357_9BDF, 1'b1, 1'b0, 32'h400, '0); n_checks++;
    if (got !== want) begin n_fails++; $display("FAIL rmid_regrant got=%h want=%h", got, want); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_starve();
    int exp_seq [12];
    int code;
`ifdef ARB_STARVE_EN
    exp_seq = '{0, 2, 0, 2, 0, 1, 0, 2, 0, 2, 0, 1};
`else
    exp_seq = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2, 0, 2};
`endif
    set_idle();
    tick();
    iREN     = 1'b1;
    dREN     = 1'b1;
    iaddr    = 32'h0000_0500;
    daddr    = 32'h0000_0600;
    ramstate = ACCESS;
    ramload  = 32'h0000_0077;
    #1;
    for (int c = 0; c < 12; c++) begin
      code = (ihit ? 1 : 0) + (dhit ? 2 : 0);
      n_checks++;
      if (code !== exp_seq[c]) begin
        n_fails++;
        $display("FAIL starve_cyc%0d hit_code=%0d want=%0d", c, code, exp_seq[c]);
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    obs_t got, want;
    for (int c = 0; c < int'(N_RAND); c++) begin
      iREN = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       begin dREN = 1'b0; dWEN = 1'b0; end
        1:       begin dREN = 1'b1; dWEN = 1'b0; end
        default: begin dREN = 1'b0; dWEN = 1'b1; end
      endcase
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = ($urandom_range(0, 1) != 0) ? 2'(ACCESS) : 2'($urandom_range(0, 3));
      #1;
      got  = sample();
      want = model_out();
      n_checks++;
      if (got !== want) begin n_fails++; $display("FAIL rand_cyc%0d got=%h want=%h", c, got, want); end
      tick();
    end
    set_idle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    set_idle();
    test_reset();
    test_ifetch();
    test_priority();
    test_busy_hold();
    test_abort();
    test_reset_mid();
    test_starve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8: consecutive data grants allowed while an instruction request waits (used only under ARB_STARVE_EN).
REQ-002 SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port nRST  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port iREN  in  1  instruction read request.
REQ-005 SHALL have port iaddr  in  32  instruction word address.
REQ-006 SHALL have port ihit  out  1  instruction read complete, one-cycle pulse.
REQ-007 SHALL have port iload  out  32  instruction data, valid while ihit=1.
REQ-008 SHALL have port dREN  in  1  data read request.
REQ-009 SHALL have port dWEN  in  1  data write request; dREN and dWEN are never asserted together.
REQ-010 SHALL have port daddr  in  32  data address.
REQ-011 SHALL have port dstore  in  32  data write value.
REQ-012 SHALL have port dhit  out  1  data access complete, one-cycle pulse.
REQ-013 SHALL have port dload  out  32  data read value, valid while dhit=1.
REQ-014 SHALL have port ramREN  out  1  RAM read strobe.
REQ-015 SHALL have port ramWEN  out  1  RAM write strobe.
REQ-016 SHALL have port ramaddr  out  32  RAM address.
REQ-017 SHALL have port ramstore  out  32  RAM write data.
REQ-018 SHALL have port ramload  in  32  RAM read data.
REQ-019 SHALL have port ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-020 SHALL implement states IDLE, IGRANT, DGRANT.
REQ-021 In IDLE, SHALL go to DGRANT if dREN|dWEN, else to IGRANT if iREN, else stay IDLE; data has priority.
REQ-022 In IDLE, SHALL drive ramREN=ramWEN=0 and ramaddr=ramstore=0.
REQ-023 In IGRANT, SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-024 In DGRANT, SHALL drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
REQ-025 RAM outputs SHALL be combinational from the state and the live request inputs.
REQ-026 In a grant state with ramstate=ACCESS, SHALL assert the matching hit for that cycle only and return to IDLE on the next edge.
REQ-027 iload and dload SHALL equal ramload while the matching hit is 1, else 0.
REQ-028 Minimum latency SHALL be 2 cycles: request sampled in IDLE, hit no earlier than the following cycle.
REQ-029 Back-to-back requests SHALL incur exactly one IDLE cycle between grants.
REQ-030 If the granted request deasserts before ACCESS, SHALL return to IDLE next edge with no hit.
REQ-031 ramstate BUSY, FREE or ERROR during a grant SHALL hold the grant with no hit.
REQ-032 ihit and dhit SHALL never be 1 in the same cycle.

Reset
REQ-033 nRST=0 SHALL force state IDLE and clear the starvation counter immediately, independent of CLK.
REQ-034 During reset, SHALL drive all outputs 0; an access in flight is dropped without a hit.

Configuration
REQ-035 Macro ARB_STARVE_EN defined: SHALL count consecutive DGRANT entries while iREN=1, saturating at STARVE_MAX.
REQ-036 With ARB_STARVE_EN, SHALL clear the count on any IGRANT entry or when iREN=0 in IDLE.
REQ-037 With ARB_STARVE_EN, in IDLE with count=STARVE_MAX and iREN=1, SHALL choose IGRANT over a pending data request.
REQ-038 ARB_STARVE_EN undefined: SHALL use strict data priority with no counter logic; STARVE_MAX is unused.

Structure
REQ-039 ramstate_t and arb_state_t SHALL be defined in cpu_types_pkg; word_t SHALL be used for all 32-bit buses.
REQ-040 Starvation counter SHALL be sub-module arb_starve_cnt, instantiated only under ARB_STARVE_EN; no other sub-modules.

Verification
REQ-041 iREN=1, iaddr=0x40, ramstate ACCESS on cycle 2, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40; ihit=1 and iload=0xDEADBEEF for one cycle.
REQ-042 iREN=1 and dWEN=1, daddr=0x80, dstore=0x1234 in the same cycle -> DGRANT first with ramWEN=1, ramstore=0x1234; dhit; one IDLE cycle; then IGRANT.
REQ-043 dREN=1, ramstate BUSY for 3 cycles then ACCESS -> grant held 3 cycles with no hit, then dhit on cycle 5.
REQ-044 With ARB_STARVE_EN and STARVE_MAX=2, iREN=1 held, data requests continuous -> 2 data grants, then 1 instruction grant.
REQ-045 nRST pulsed low mid-DGRANT -> outputs 0 asynchronously, no dhit, state IDLE after release.
